// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain consumer for the async FIFO: pops words, absorbs the 1-cycle read
// latency and re-presents them as a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 rd_enable,
    output logic                 r_en,
    input  logic [WIDTH-1:0]     data_out,
    input  logic                 empty,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] pop_count
);

    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;
    logic [1:0]       occ;
    logic             inflight;
    logic             take;
    logic [1:0]       space;
    logic [1:0]       slot;
    logic [1:0]       occ_next;

    // Handshake: a word moves downstream on every posedge where m_valid and
    // m_ready are both high; m_data is held while m_valid=1 and m_ready=0.
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign occupancy = occ;
    assign take      = m_valid & m_ready;

    // occ + inflight never exceeds 2, so the credit count stays within 0..2.
    // The take term lets m_ready reach r_en combinationally for full throughput.
    assign space    = 2'd2 - occ - {1'b0, inflight} + {1'b0, take};
    assign r_en     = r_rst & rd_enable & ~empty & (space != 2'd0);
    assign slot     = occ - {1'b0, take};
    assign occ_next = occ - {1'b0, take} + {1'b0, inflight};

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            buf0      <= '0;
            buf1      <= '0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            pop_count <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= r_en;
            if (take) begin
                pop_count <= pop_count + CNT_WIDTH'(1);
            end
            if (take && (occ == 2'd2)) begin
                buf0 <= buf1;
            end
            // The returning word lands in the slot left after any shift.
            if (inflight) begin
                if (slot == 2'd0) begin
                    buf0 <= data_out;
                end else begin
                    buf1 <= data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue-based FIFO model feeds the DUT and a
// scoreboard checks the stream against the words popped from that model.
module tb_fifo_rd_stream_adapter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rd_enable = 1'b0;
    logic             r_en;
    logic [WIDTH-1:0] data_out = '0;
    logic             empty = 1'b1;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] pop_count;

    fifo_rd_stream_adapter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
        .r_clk     (clk),
        .r_rst     (rst_n),
        .rd_enable (rd_enable),
        .r_en      (r_en),
        .data_out  (data_out),
        .empty     (empty),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .pop_count (pop_count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               take_cyc[$];
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    int               fires = 0;
    int               first_fire = -1;
    int               deliv = 0;
    logic             pop_req = 1'b0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on negedge, compares stream words against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("r_en_in_reset", {31'd0, r_en}, 32'd0);
            pop_req    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("occupancy_max", {31'd0, (occupancy <= 2'd2)}, 32'd1);
            if (r_en && empty)      check("r_en_while_empty", 32'd1, 32'd0);
            if (r_en && !rd_enable) check("r_en_while_disabled", 32'd1, 32'd0);
            if (stall_prev) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {24'd0, m_data}, {24'd0, stall_data});
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            pop_req = r_en && !empty;
            if (pop_req) begin
                fires++;
                if (first_fire < 0) first_fire = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    check("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
                check("pop_count", {28'd0, pop_count}, 32'(deliv % (1 << CNT_W)));
                deliv++;
                take_cyc.push_back(cyc);
            end
        end
    end

    // One clock: FIFO read port model returns the popped word one cycle later.
    task automatic cycle();
        logic was_rst;
        logic [WIDTH-1:0] w;
        @(posedge clk);
        was_rst = !rst_n;
        #1;
        if (pop_req) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            data_out = w;
        end else begin
            data_out = WIDTH'($urandom);
        end
        if (was_rst) begin
            exp_q.delete();
            deliv = 0;
        end
        empty = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_words(input int n, input logic [WIDTH-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? WIDTH'($urandom) : WIDTH'(base + i));
        empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input string name);
        int left;
        rd_enable = 1'b1;
        m_ready   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && occupancy == 2'd0) break;
            cycle();
        end
        left = fifo_q.size() + exp_q.size() + int'(occupancy);
        check(name, 32'(left), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int fbase;
        // Reset with 5 words waiting and m_ready high.
        rd_enable = 1'b1;
        m_ready   = 1'b1;
        run(1);
        push_words(5, 8'hA0, 1'b0);
        run(3);
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_occupancy", {30'd0, occupancy}, 32'd0);
        check("reset_m_data", {24'd0, m_data}, 32'd0);
        take_cyc.delete();
        first_fire = -1;
        rst_n = 1'b1;
        run(12);
        check("t1_words", 32'(take_cyc.size()), 32'd5);
        if (take_cyc.size() == 5) begin
            check("t1_first_latency", 32'(take_cyc[0] - first_fire), 32'd2);
            check("t1_back_to_back", 32'(take_cyc[4] - take_cyc[0]), 32'd4);
        end
        check("t1_pop_count", {28'd0, pop_count}, 32'd5);

        // Stalled sink: exactly two pops, head held, then full-rate release.
        m_ready = 1'b0;
        fbase = fires;
        push_words(8, 8'h11, 1'b0);
        run(6);
        check("t2_pops", 32'(fires - fbase), 32'd2);
        check("t2_occupancy", {30'd0, occupancy}, 32'd2);
        check("t2_head", {24'd0, m_data}, 32'h11);
        take_cyc.delete();
        m_ready = 1'b1;
        run(12);
        check("t2_words", 32'(take_cyc.size()), 32'd8);
        if (take_cyc.size() == 8) check("t2_no_gap", 32'(take_cyc[7] - take_cyc[0]), 32'd7);

        // Toggling ready plus random enables and random data.
        for (int i = 0; i < 80; i++) begin
            m_ready   = i[0];
            rd_enable = ($urandom_range(0, 3) != 0);
            push_words($urandom_range(0, 2), 8'h00, 1'b1);
            cycle();
        end
        drain("t3_drain");

        // rd_enable dropped right after a pop: in-flight word must still arrive.
        push_words(4, 8'h40, 1'b0);
        cycle();
        rd_enable = 1'b0;
        run(6);
        check("t4_inflight_delivered", 32'(exp_q.size()), 32'd0);
        check("t4_fifo_left", 32'(fifo_q.size()), 32'd3);
        check("t4_idle_occupancy", {30'd0, occupancy}, 32'd0);
        drain("t4_drain");

        // Reset with a full skid buffer.
        m_ready = 1'b0;
        push_words(4, 8'h60, 1'b0);
        run(5);
        check("t5_full", {30'd0, occupancy}, 32'd2);
        rst_n = 1'b0;
        cycle();
        check("t5_m_valid", {31'd0, m_valid}, 32'd0);
        check("t5_occupancy", {30'd0, occupancy}, 32'd0);
        check("t5_pop_count", {28'd0, pop_count}, 32'd0);
        rst_n = 1'b1;
        drain("t5_drain");

        // Reset with a word in flight: it is discarded, the rest follow.
        push_words(3, 8'h70, 1'b0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("t5b_m_valid", {31'd0, m_valid}, 32'd0);
        rst_n = 1'b1;
        drain("t5b_drain");

        // Counter wrap: 17 words after reset.
        do_reset();
        push_words(17, 8'h80, 1'b1);
        drain("t6_drain");
        check("t6_wrap", {28'd0, pop_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
